// File: rtl/output_data_writer.sv
// Drains systolic-array result vectors into RAM, one valid lane per cycle, in row-major order.
// Optional build macro OUTPUT_RELU_EN clamps negative lane words to zero on the write path.
module output_data_writer #(
  parameter int unsigned data_size     = 16,
  parameter int unsigned array_size    = 9,
  parameter int unsigned dim_data_size = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [13:0]                      initial_address,
  input  logic [dim_data_size-1:0]         out_height,
  input  logic [dim_data_size-1:0]         out_width,
  input  logic [dim_data_size-1:0]         offset,
  input  logic [array_size-1:0]            valid_in,
  input  logic [array_size*data_size-1:0]  data_in,
  output logic                             in_ready,
  output logic [13:0]                      ram_address,
  output logic [data_size-1:0]             ram_data,
  output logic                             ram_we,
  output logic                             completed
);

  localparam int unsigned AW = 14;
  localparam int unsigned DW = dim_data_size;
  localparam int unsigned LW = (array_size > 1) ? $clog2(array_size) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                        state_q, state_d;
  logic [DW-1:0]                 h_q, h_d, w_q, w_d, off_q, off_d;
  logic [DW-1:0]                 row_q, row_d, col_q, col_d;
  logic [AW-1:0]                 base_q, base_d, row_off_q, row_off_d;
  logic [array_size-1:0]         mask_q, mask_d;
  logic [array_size*data_size-1:0] buf_q, buf_d;
  logic                          last_q, last_d;
  logic                          in_ready_d, ram_we_d, completed_d;
  logic [AW-1:0]                 ram_address_d;
  logic [data_size-1:0]          ram_data_d;

  logic [array_size-1:0]         src_mask;
  logic [array_size*data_size-1:0] src_data;
  logic [LW-1:0]                 lane_idx;
  logic [data_size-1:0]          lane_word, wr_word;
  logic                          issue;

  // Lowest-index pending lane, taken from the live input while collecting, else from the buffer
  always_comb begin
    src_mask  = (state_q == COLLECT) ? valid_in : mask_q;
    src_data  = (state_q == COLLECT) ? data_in : buf_q;
    lane_idx  = '0;
    lane_word = '0;
    for (int i = int'(array_size) - 1; i >= 0; i--) begin
      if (src_mask[i]) begin
        lane_idx  = LW'(i);
        lane_word = src_data[i*data_size +: data_size];
      end
    end
  end

`ifdef OUTPUT_RELU_EN
  assign wr_word = lane_word[data_size-1] ? '0 : lane_word;
`else
  assign wr_word = lane_word;
`endif

  // Next-state and registered-output logic; a write is staged into the output registers
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    w_d           = w_q;
    off_d         = off_q;
    base_d        = base_q;
    row_d         = row_q;
    col_d         = col_q;
    row_off_d     = row_off_q;
    mask_d        = mask_q;
    buf_d         = buf_q;
    last_d        = last_q;
    ram_we_d      = 1'b0;
    ram_address_d = ram_address;
    ram_data_d    = ram_data;
    issue         = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          h_d       = out_height;
          w_d       = out_width;
          off_d     = offset;
          base_d    = initial_address;
          row_d     = '0;
          col_d     = '0;
          row_off_d = '0;
          mask_d    = '0;
          last_d    = 1'b0;
          state_d   = (out_height == '0 || out_width == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (|valid_in) begin
          buf_d   = data_in;
          issue   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!enable) begin
          state_d = IDLE;
          mask_d  = '0;
        end else if (last_q) begin
          state_d = DONE;
          mask_d  = '0;
        end else if (|mask_q) begin
          issue = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      ram_we_d         = 1'b1;
      ram_data_d       = wr_word;
      ram_address_d    = base_q + row_off_q + AW'(col_q);
      mask_d           = src_mask;
      mask_d[lane_idx] = 1'b0;
      last_d           = (row_q == h_q - DW'(1)) && (col_q == w_q - DW'(1));
      if (col_q == w_q - DW'(1)) begin
        col_d     = '0;
        row_d     = row_q + DW'(1);
        row_off_d = row_off_q + AW'(off_q);
      end else begin
        col_d = col_q + DW'(1);
      end
    end

    in_ready_d  = (state_d == COLLECT);
    completed_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      h_q         <= '0;
      w_q         <= '0;
      off_q       <= '0;
      base_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      row_off_q   <= '0;
      mask_q      <= '0;
      buf_q       <= '0;
      last_q      <= 1'b0;
      in_ready    <= 1'b0;
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      completed   <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      w_q         <= w_d;
      off_q       <= off_d;
      base_q      <= base_d;
      row_q       <= row_d;
      col_q       <= col_d;
      row_off_q   <= row_off_d;
      mask_q      <= mask_d;
      buf_q       <= buf_d;
      last_q      <= last_d;
      in_ready    <= in_ready_d;
      ram_we      <= ram_we_d;
      ram_address <= ram_address_d;
      ram_data    <= ram_data_d;
      completed   <= completed_d;
    end
  end

endmodule

// File: tb/tb_output_data_writer.sv
// Bench for output_data_writer: directed scenarios plus randomized runs against a
// row-major write-list model (write k lands at base + (k/w)*offset + k%w, mod 2^14).
module tb_output_data_writer;

  localparam int unsigned DS = 16;
  localparam int unsigned AS = 9;
  localparam int unsigned DW = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [13:0]        initial_address;
  logic [DW-1:0]      out_height, out_width, offset;
  logic [AS-1:0]      valid_in;
  logic [AS*DS-1:0]   data_in;
  logic               in_ready;
  logic [13:0]        ram_address;
  logic [DS-1:0]      ram_data;
  logic               ram_we;
  logic               completed;

  always #5 clk = ~clk;

  output_data_writer #(.data_size(DS), .array_size(AS), .dim_data_size(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .initial_address(initial_address),
    .out_height(out_height), .out_width(out_width), .offset(offset),
    .valid_in(valid_in), .data_in(data_in), .in_ready(in_ready),
    .ram_address(ram_address), .ram_data(ram_data), .ram_we(ram_we), .completed(completed)
  );

  int n_cmp = 0;
  int n_err = 0;
  int got_a[$], got_d[$], exp_a[$], exp_d[$];
  longint cur_base, cur_h, cur_w, cur_off;
  longint n_exp;

  // Write capture, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      got_a.push_back(int'(ram_address));
      got_d.push_back(int'(ram_data));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int relu(input int w);
`ifdef OUTPUT_RELU_EN
    return (w >= 32768) ? 0 : w;
`else
    return w;
`endif
  endfunction

  function automatic void model_vec(input logic [AS-1:0] v, input logic [AS*DS-1:0] d);
    for (int i = 0; i < int'(AS); i++) begin
      if (v[i] && n_exp < cur_h * cur_w) begin
        exp_a.push_back(int'((cur_base + (n_exp / cur_w) * cur_off + (n_exp % cur_w)) % 16384));
        exp_d.push_back(relu(int'(d[i*DS +: DS])));
        n_exp++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int base, input int h, input int w, input int off);
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    n_exp = 0;
    cur_base = base; cur_h = h; cur_w = w; cur_off = off;
    initial_address = 14'(base);
    out_height = DW'(h);
    out_width = DW'(w);
    offset = DW'(off);
    enable = 1'b1;
    tick();
  endtask

  task automatic accept(input logic [AS-1:0] v, input logic [AS*DS-1:0] d);
    for (int i = 0; i < 30 && in_ready !== 1'b1; i++) tick();
    if (in_ready !== 1'b1) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    model_vec(v, d);
    valid_in = v;
    data_in = d;
    tick();
    valid_in = '0;
  endtask

  task automatic settle();
    for (int i = 0; i < 30 && in_ready !== 1'b1 && completed !== 1'b1; i++) tick();
    if (in_ready !== 1'b1 && completed !== 1'b1) chk("settle_timeout", 0, 1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, got_a.size(), exp_a.size());
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      chk({tag, "_addr"}, got_a[i], exp_a[i]);
      chk({tag, "_data"}, got_d[i], exp_d[i]);
    end
  endtask

  task automatic stop_run();
    enable = 1'b0;
    tick();
  endtask

  logic [AS*DS-1:0] d;
  int basic_a[6] = '{100, 101, 102, 108, 109, 110};
  int it;

  initial begin
    reset = 1'b0; enable = 1'b0; initial_address = '0;
    out_height = '0; out_width = '0; offset = '0; valid_in = '0; data_in = '0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_completed", completed, 0);
    reset = 1'b1;
    tick();

    // Basic run
    start(100, 2, 3, 8);
    chk("basic_in_ready", in_ready, 1);
    for (int i = 0; i < int'(AS); i++) d[i*DS +: DS] = DS'(i + 1);
    accept(9'h1FF, d);
    settle();
    chk("basic_completed", completed, 1);
    check_writes("basic");
    for (int i = 0; i < 6; i++) begin
      chk("basic_addr_const", (got_a.size() > i) ? got_a[i] : -1, basic_a[i]);
      chk("basic_data_const", (got_d.size() > i) ? got_d[i] : -1, i + 1);
    end
    stop_run();
    chk("basic_idle_completed", completed, 0);

    // Sparse lanes
    start(40, 1, 4, 0);
    for (int i = 0; i < int'(AS); i++) d[i*DS +: DS] = DS'($urandom_range(0, 32767));
    accept(9'b100000101, d);
    chk("sparse_we0", ram_we, 1);
    tick();
    chk("sparse_we1", ram_we, 1);
    tick();
    chk("sparse_we2", ram_we, 1);
    tick();
    chk("sparse_ready_again", in_ready, 1);
    chk("sparse_we_off", ram_we, 0);
    check_writes("sparse");
    stop_run();

    // Address wrap
    start(16383, 1, 2, 5);
    accept(9'h003, d);
    settle();
    check_writes("wrap");
    chk("wrap_addr0", (got_a.size() > 0) ? got_a[0] : -1, 16383);
    chk("wrap_addr1", (got_a.size() > 1) ? got_a[1] : -1, 0);
    stop_run();

    // Abort after the 2nd write
    start(200, 2, 3, 4);
    accept(9'h1FF, d);
    tick();
    enable = 1'b0;
    tick();
    chk("abort_we", ram_we, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_completed", completed, 0);
    repeat (3) tick();
    chk("abort_count", got_a.size(), 2);
    for (int i = 0; i < 2 && i < got_a.size(); i++) chk("abort_addr", got_a[i], exp_a[i]);

    // Async reset mid-drain
    start(50, 2, 3, 1);
    accept(9'h1FF, d);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_ram_we", ram_we, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_ram_address", ram_address, 0);
    chk("arst_ram_data", ram_data, 0);
    chk("arst_completed", completed, 0);
    enable = 1'b0;
    #3 reset = 1'b1;
    tick();
    chk("arst_idle_we", ram_we, 0);

    // Negative-word handling
    start(300, 1, 2, 0);
    d = '0;
    d[0 +: DS] = 16'hFFF0;
    d[DS +: DS] = 16'h0010;
    accept(9'h003, d);
    settle();
    check_writes("relu");
`ifdef OUTPUT_RELU_EN
    chk("relu_neg", (got_d.size() > 0) ? got_d[0] : -1, 0);
`else
    chk("relu_neg", (got_d.size() > 0) ? got_d[0] : -1, 16'hFFF0);
`endif
    chk("relu_pos", (got_d.size() > 1) ? got_d[1] : -1, 16'h0010);
    stop_run();

    // Zero dimension
    start(10, 3, 0, 1);
    tick();
    chk("zero_completed", completed, 1);
    chk("zero_in_ready", in_ready, 0);
    chk("zero_writes", got_a.size(), 0);
    stop_run();

    // Randomized runs; dimensions scrambled after start must not matter
    for (int r = 0; r < 8; r++) begin
      start(int'($urandom_range(0, 16383)), int'($urandom_range(1, 4)),
            int'($urandom_range(1, 5)), int'($urandom_range(0, 300)));
      out_height = DW'($urandom);
      out_width = DW'($urandom);
      offset = DW'($urandom);
      initial_address = 14'($urandom);
      it = 0;
      while (completed !== 1'b1 && it < 60) begin
        for (int i = 0; i < int'(AS); i++) d[i*DS +: DS] = DS'($urandom);
        accept(($urandom_range(0, 4) == 0) ? AS'(0) : AS'($urandom_range(1, 511)), d);
        settle();
        it++;
      end
      chk("rand_completed", completed, 1);
      check_writes("rand");
      stop_run();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_data_writer.md
OUTPUT_DATA_WRITER -- requirements
Module: output_data_writer

Interface
REQ-001 Parameters SHALL be: data_size, default 16, width of one result word; array_size, default 9, number of systolic array output lanes; dim_data_size, default 16, width of the dimension inputs.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- enable  in  1  run request.
- initial_address  in  14  RAM base address.
- out_height  in  dim_data_size  output rows.
- out_width  in  dim_data_size  output columns.
- offset  in  dim_data_size  RAM row stride.
- valid_in  in  array_size  per-lane result valid.
- data_in  in  array_size*data_size  lane results, lane i at bits [i*data_size +: data_size].
- in_ready  out  1  vector may be accepted.
- ram_address  out  14  write address.
- ram_data  out  data_size  write data.
- ram_we  out  1  write strobe.
- completed  out  1  all results written.

Function
REQ-003 The block SHALL be a four-state FSM: IDLE, COLLECT, DRAIN, DONE.
REQ-004 From IDLE with enable=1, the block SHALL latch the dimensions, offset and initial_address, clear row and column counters, and enter COLLECT next cycle; if out_height=0 or out_width=0, it SHALL enter DONE instead.
REQ-005 in_ready SHALL be 1 only in COLLECT.
REQ-006 In COLLECT, a vector SHALL be accepted when valid_in is non-zero; data_in and valid_in are then registered into a holding buffer and the FSM enters DRAIN. An all-zero valid_in SHALL be ignored.
REQ-007 In DRAIN, the block SHALL write one valid lane per cycle in ascending lane index, skipping invalid lanes at zero cost: ram_we=1, ram_data equals the lane word, ram_address=initial_address + row*offset + col.
REQ-008 After each write, col SHALL increment; at col=out_width-1 it SHALL wrap to 0 and row SHALL increment.
REQ-009 Address arithmetic SHALL be computed at full width and truncated to 14 bits (modulo 2^14 wrap).
REQ-010 When the write for row=out_height-1, col=out_width-1 completes, the FSM SHALL enter DONE; any remaining buffered lanes SHALL be discarded.
REQ-011 When the last buffered valid lane is written and the total has not been reached, the FSM SHALL return to COLLECT on the next cycle.
REQ-012 The first write SHALL occur the cycle after acceptance; ram_we SHALL be 0 in all states except DRAIN.
REQ-013 In DONE, completed SHALL be 1 and SHALL remain 1 until enable=0, which SHALL return the FSM to IDLE.
REQ-014 enable=0 in COLLECT or DRAIN SHALL abort to IDLE on the next edge, with no further writes; the holding buffer SHALL be invalidated.
REQ-015 Dimension or offset changes after the start SHALL NOT affect the current run.

Reset
REQ-016 With reset=0, the block SHALL asynchronously enter IDLE and clear the counters and holding buffer valid bits.
REQ-017 During reset, outputs SHALL be: in_ready=0, ram_we=0, ram_address=0, ram_data=0, completed=0.
REQ-018 Reset asserted mid-DRAIN SHALL suppress ram_we within the same cycle.

Configuration
REQ-019 With OUTPUT_RELU_EN defined, ram_data SHALL be 0 whenever the lane word's MSB is 1 (signed negative), and the lane word otherwise.
REQ-020 Without OUTPUT_RELU_EN, ram_data SHALL be the lane word unmodified; timing is identical in both builds.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Basic run: initial_address=100, out_height=2, out_width=3, offset=8; one vector with all 9 lanes valid, lane i=i+1. Required: 6 writes at addresses 100,101,102,108,109,110 carrying data 1..6, lanes 6-8 dropped, then completed=1.
- Sparse lanes: valid_in=9'b100000101, out_width=4, out_height=1. Required: 3 consecutive writes (lanes 0,2,8) at col 0..2, in_ready=1 again on the next cycle.
- Address wrap: initial_address=16383, out_width=2, out_height=1. Required: addresses 16383 then 0.
- Abort: enable dropped after the 2nd of 6 writes. Required: no further ram_we, IDLE next cycle, completed=0.
- Async reset: reset pulsed low mid-DRAIN between clock edges. Required: ram_we=0 immediately and all outputs at their reset values.
- OUTPUT_RELU_EN build: lane word 16'hFFF0 written as 0; 16'h0010 written unchanged. Without the macro, 16'hFFF0 written unchanged.
- Zero dimension: out_width=0. Required: completed=1 two cycles after enable, with no writes.
